// File: rtl/nxm_monitor_pkg.sv
// nxm_monitor_pkg: shared FSM encoding, default timeouts, CSR status bit positions and the busIO address decode
package nxm_monitor_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int KS10_MEM_TIMEOUT = 15;
  localparam int KS10_IO_TIMEOUT = 63;
  localparam int BUS_IO_BIT = 6;
  localparam int NXM_ERR_BIT = 0;
  localparam int NXM_OVF_BIT = 1;
  localparam int NXM_IO_BIT = 2;
  function automatic logic bus_io(input logic [0:35] a);
    return a[BUS_IO_BIT];
  endfunction
endpackage

// File: rtl/nxm_timer.sv
// nxm_timer: loadable down-counter (clk, rst, load/val, dec, clr) with terminal count tc at value 1
module nxm_timer #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic            clr,
  input  logic [CNTW-1:0] val,
  output logic            tc
);
  logic [CNTW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec) cnt <= cnt - 1'b1;
  assign tc = cnt == CNTW'(1);
endmodule

// File: rtl/nxm_monitor.sv
// nxm_monitor: KS-10 bus-cycle monitor; cpuADDRO/cpuREQO/cpuACKI/nxmCLR in, memWAIT/ioWAIT stalls, nxmINTR pulse, sticky nxmERR/nxmOVF/nxmIO/nxmADDR out; IO monitoring enabled by KS10_NXM_IO_TIMEOUT_EN
import nxm_monitor_pkg::*;
module nxm_monitor #(
  parameter int MEM_TIMEOUT = KS10_MEM_TIMEOUT,
  parameter int IO_TIMEOUT = KS10_IO_TIMEOUT,
  parameter int CNTW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:35] cpuADDRO,
  input  logic        cpuREQO,
  input  logic        cpuACKI,
  input  logic        nxmCLR,
  output logic        memWAIT,
  output logic        ioWAIT,
  output logic        nxmINTR,
  output logic        nxmERR,
  output logic        nxmOVF,
  output logic        nxmIO,
  output logic [0:35] nxmADDR
);
`ifdef KS10_NXM_IO_TIMEOUT_EN
  localparam logic IO_EN = 1'b1;
`else
  localparam logic IO_EN = 1'b0;
`endif
  state_t state, state_n;
  logic io, mon, idle, load, clr_t, dec, timeout, tc, pend_io;
  logic [0:35] pend_addr;
  assign io = bus_io(cpuADDRO);
  assign mon = cpuREQO & !cpuACKI & (IO_EN | !io);
  assign idle = state == IDLE;
  always_comb begin
    state_n = state;
    load = 1'b0;
    clr_t = 1'b0;
    dec = 1'b0;
    timeout = 1'b0;
    if (idle) begin
      load = mon;
      state_n = mon ? WAIT : IDLE;
    end else begin
      clr_t = cpuACKI | tc;
      timeout = !cpuACKI & tc;
      dec = !cpuACKI & !tc;
      state_n = (cpuACKI | tc) ? IDLE : WAIT;
    end
  end
  nxm_timer #(.CNTW(CNTW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .dec(dec),
    .clr(clr_t),
    .val(io ? CNTW'(IO_TIMEOUT) : CNTW'(MEM_TIMEOUT)),
    .tc(tc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pend_addr <= '0;
      pend_io <= 1'b0;
      nxmINTR <= 1'b0;
      nxmERR <= 1'b0;
      nxmOVF <= 1'b0;
      nxmIO <= 1'b0;
      nxmADDR <= '0;
    end else begin
      state <= state_n;
      nxmINTR <= timeout;
      if (load) begin
        pend_addr <= cpuADDRO;
        pend_io <= io & IO_EN;
      end
      if (timeout && (nxmCLR || !nxmERR)) begin
        nxmERR <= 1'b1;
        nxmOVF <= 1'b0;
        nxmIO <= pend_io;
        nxmADDR <= pend_addr;
      end else if (timeout) nxmOVF <= 1'b1;
      else if (nxmCLR) begin
        nxmERR <= 1'b0;
        nxmOVF <= 1'b0;
        nxmIO <= 1'b0;
        nxmADDR <= '0;
      end
    end
  assign memWAIT = !cpuACKI & ((idle & cpuREQO & !io) | (!idle & !pend_io));
  assign ioWAIT = IO_EN & !cpuACKI & ((idle & cpuREQO & io) | (!idle & pend_io));
endmodule

// File: tb/tb_nxm_monitor.sv
// tb_nxm_monitor: scoreboard bench; stimulus queues per-cycle expected outputs, a negedge monitor pops and compares
module tb_nxm_monitor;
`ifdef KS10_NXM_IO_TIMEOUT_EN
  localparam logic IO_EN = 1'b1;
`else
  localparam logic IO_EN = 1'b0;
`endif
  typedef struct packed {
    logic mw, iw, intr, err, ovf, io;
    logic [35:0] addr;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [0:35] addr = '0;
  logic mem_wait, io_wait, intr, err, ovf, nio;
  logic [0:35] naddr;
  logic e_err = 1'b0, e_ovf = 1'b0, e_io = 1'b0;
  logic [0:35] e_addr = '0;
  exp_t eq[$];
  string nq[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  nxm_monitor #(.MEM_TIMEOUT(15), .IO_TIMEOUT(63), .CNTW(8)) dut (
    .clk(clk),
    .rst(rst),
    .cpuADDRO(addr),
    .cpuREQO(req),
    .cpuACKI(ack),
    .nxmCLR(clr),
    .memWAIT(mem_wait),
    .ioWAIT(io_wait),
    .nxmINTR(intr),
    .nxmERR(err),
    .nxmOVF(ovf),
    .nxmIO(nio),
    .nxmADDR(naddr)
  );
  always @(negedge clk)
    if (eq.size() > 0) begin
      exp_t e, a;
      string n;
      e = eq.pop_front();
      n = nq.pop_front();
      a = {mem_wait, io_wait, intr, err, ovf, nio, naddr};
      total++;
      if (a !== e) $display("FAIL %s: got mw=%b iw=%b intr=%b err=%b ovf=%b io=%b addr=%o, expected mw=%b iw=%b intr=%b err=%b ovf=%b io=%b addr=%o",
        n, a.mw, a.iw, a.intr, a.err, a.ovf, a.io, a.addr, e.mw, e.iw, e.intr, e.err, e.ovf, e.io, e.addr);
      else passed++;
    end
  task automatic cyc(input logic r, a, c, x, input logic [0:35] ad, input logic mw, iw, it, input string nm);
    req = r;
    ack = a;
    clr = c;
    rst = x;
    addr = ad;
    eq.push_back({mw, iw, it, e_err, e_ovf, e_io, e_addr});
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  task automatic bus(input logic [0:35] ad, input int ak, input logic cl, input string nm);
    logic io;
    int t;
    io = ad[6];
    t = io ? 63 : 15;
    if (io && !IO_EN) begin
      for (int c = 0; c < 70; c++) cyc(1, 0, 0, 0, ad, 0, 0, 0, nm);
      cyc(0, 0, 0, 0, ad, 0, 0, 0, {nm, "_end"});
      return;
    end
    for (int c = 0; c <= t; c++) begin
      cyc(1, c == ak, cl && c == t, 0, ad, !io && c != ak, io && c != ak, 0, nm);
      if (c == ak) begin
        cyc(0, 0, 0, 0, ad, 0, 0, 0, {nm, "_post"});
        return;
      end
    end
    if (cl || !e_err) begin
      e_err = 1'b1;
      e_ovf = 1'b0;
      e_addr = ad;
      e_io = io;
    end else e_ovf = 1'b1;
    cyc(0, 0, 0, 0, ad, 0, 0, 1, {nm, "_intr"});
    total++;
    if (mem_wait !== 1'b0 || io_wait !== 1'b0 || err !== e_err || ovf !== e_ovf || nio !== e_io || naddr !== e_addr)
      $display("FAIL %s_expired: got mw=%b iw=%b err=%b ovf=%b io=%b addr=%o, expected mw=0 iw=0 err=%b ovf=%b io=%b addr=%o",
        nm, mem_wait, io_wait, err, ovf, nio, naddr, e_err, e_ovf, e_io, e_addr);
    else passed++;
    cyc(0, 0, 0, 0, ad, 0, 0, 0, {nm, "_after"});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_wait, io_wait, intr, err, ovf, nio, naddr} !== '0)
      $display("FAIL reset_direct: got mw=%b iw=%b intr=%b err=%b ovf=%b io=%b addr=%o, expected all 0",
        mem_wait, io_wait, intr, err, ovf, nio, naddr);
    else passed++;
    cyc(0, 0, 0, 0, '0, 0, 0, 0, "reset_state");
    bus(36'o000000001000, 3, 0, "mem_ack3");
    bus(36'o000000777777, -1, 0, "mem_timeout");
    bus(36'o000000003000, -1, 0, "mem_overflow");
    cyc(0, 0, 1, 0, '0, 0, 0, 0, "clr");
    e_err = 1'b0;
    e_ovf = 1'b0;
    e_io = 1'b0;
    e_addr = '0;
    cyc(0, 0, 0, 0, '0, 0, 0, 0, "clr_after");
    bus(36'o000000005000, -1, 0, "mem_timeout2");
    bus(36'o000000002000, -1, 1, "clr_vs_timeout");
    bus(36'o000000004000, 0, 0, "zero_wait");
    bus(36'o000000007000, 15, 0, "ack_at_T");
    bus(36'o000000006000, 0, 0, "back_to_back");
    bus(36'o004000000100, -1, 0, "io_cycle");
    for (int c = 0; c < 5; c++) cyc(1, 0, 0, 0, 36'o000000010000, 1, 0, 0, "rst_pre");
    cyc(1, 0, 0, 1, 36'o000000010000, 1, 0, 0, "rst_c5");
    e_err = 1'b0;
    e_ovf = 1'b0;
    e_io = 1'b0;
    e_addr = '0;
    for (int c = 0; c < 20; c++) cyc(0, 0, 0, 0, '0, 0, 0, 0, "rst_after");
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
